signmag_convert_pipe: RTL and testbench



---
 rtl/signmag_pkg.sv | 13 +
 rtl/signmag_convert_core.sv | 49 ++++
 rtl/signmag_convert_pipe.sv | 106 ++++++++++
 tb/tb_signmag_convert_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/signmag_pkg.sv
// Shared encodings for the sign-magnitude / two's-complement converter.
// Mode values, flag bit positions and default geometry.
package signmag_pkg;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;

  localparam logic MODE_SM2TC = 1'b0;
  localparam logic MODE_TC2SM = 1'b1;

  localparam int FLAG_NEGZERO = 0;
  localparam int FLAG_SAT     = 1;
  localparam int FLAG_W       = 2;
endpackage

// File: rtl/signmag_convert_core.sv
// Combinational single-word converter; zero latency, no flow control.
// Selects sign-mag -> two's comp or the reverse and raises the matching flag.
module signmag_convert_core
  import signmag_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  output logic [WIDTH-1:0] out_data,
  output logic             negzero,
  output logic             sat
);
  logic             sign;
  logic [WIDTH-2:0] low;
  logic             low_zero;
  logic [WIDTH-1:0] neg_mag;
  logic [WIDTH-1:0] neg_in;

  assign sign     = in_data[WIDTH-1];
  assign low      = in_data[WIDTH-2:0];
  assign low_zero = (low == '0);
  assign neg_mag  = ~{1'b0, low} + WIDTH'(1);
  assign neg_in   = ~in_data + WIDTH'(1);

  // The most negative two's-complement value has no magnitude encoding; clamp to {1, all ones}.
  always_comb begin
    out_data = in_data;
    negzero  = 1'b0;
    sat      = 1'b0;
    if (sign) begin
      if (mode == MODE_SM2TC) begin
        if (low_zero) begin
          out_data = '0;
          negzero  = 1'b1;
        end else begin
          out_data = neg_mag;
        end
      end else begin
        if (low_zero) begin
          out_data = '1;
          sat      = 1'b1;
        end else begin
          out_data = {1'b1, neg_in[WIDTH-2:0]};
        end
      end
    end
  end
endmodule

// File: rtl/signmag_convert_pipe.sv
// Multi-channel two-stage converter pipe: 2-cycle latency, 1 word/cycle.
// Stalls from out_ready ripple back through both stages to in_ready; held outputs stay stable.
module signmag_convert_pipe
  import signmag_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int CNT_W    = 16,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CH_W-1:0]  in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_negzero,
  output logic             out_sat,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_mode,
  input  logic             evt_clear,
  output logic [CNT_W-1:0] evt_count
);
  logic [CHANNELS-1:0] mode_q;
  logic                cur_mode;
  logic                accept;
  logic                adv1;
  logic                adv2;
  logic                evt_inc;

  logic [WIDTH-1:0]    conv_data;
  logic                conv_negzero;
  logic                conv_sat;

  logic                s1_valid;
  logic [WIDTH-1:0]    s1_data;
  logic [CH_W-1:0]     s1_ch;
  logic [FLAG_W-1:0]   s1_flags;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && in_ready;
  // Read before this cycle's cfg write lands, so a coincident write affects only later words.
  assign cur_mode = mode_q[in_ch];
  assign evt_inc  = out_valid && out_ready && (out_negzero || out_sat);

  signmag_convert_core #(.WIDTH(WIDTH)) u_core (
    .in_data  (in_data),
    .mode     (cur_mode),
    .out_data (conv_data),
    .negzero  (conv_negzero),
    .sat      (conv_sat)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q      <= '0;
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_ch       <= '0;
      s1_flags    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      out_negzero <= 1'b0;
      out_sat     <= 1'b0;
      evt_count   <= '0;
    end else begin
      if (cfg_we) begin
        mode_q[cfg_ch] <= cfg_mode;
      end

      if (adv1) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data                <= conv_data;
          s1_ch                  <= in_ch;
          s1_flags[FLAG_NEGZERO] <= conv_negzero;
          s1_flags[FLAG_SAT]     <= conv_sat;
        end
      end

      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data    <= s1_data;
          out_ch      <= s1_ch;
          out_negzero <= s1_flags[FLAG_NEGZERO];
          out_sat     <= s1_flags[FLAG_SAT];
        end
      end

      if (evt_clear) begin
        evt_count <= '0;
      end else if (evt_inc && (evt_count != '1)) begin
        evt_count <= evt_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_signmag_convert_pipe.sv
// Self-checking bench: vector table plus scoreboard, with stall, config-race, counter and reset sequences.
module tb_signmag_convert_pipe;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;
  localparam int CNT_W    = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CH_W-1:0]  in_ch;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CH_W-1:0]  out_ch;
  logic             out_negzero;
  logic             out_sat;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic             cfg_mode;
  logic             evt_clear;
  logic [CNT_W-1:0] evt_count;

  always #5 CLK = ~CLK;

  signmag_convert_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_ch       (in_ch),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_negzero (out_negzero),
    .out_sat     (out_sat),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .evt_clear   (evt_clear),
    .evt_count   (evt_count)
  );

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] exp;
    logic             nz;
    logic             sat;
  } vec_t;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] data;
    logic             nz;
    logic             sat;
  } out_t;

  out_t sb[$];
  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic saw_block = 1'b0;
  logic prev_stall = 1'b0;
  out_t prev_out;

  function automatic vec_t mk(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d,
                              input logic [WIDTH-1:0] e, input logic nz, input logic sat);
    vec_t v;
    v.ch = ch; v.data = d; v.exp = e; v.nz = nz; v.sat = sat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
  always @(negedge CLK) begin
    out_t cur;
    cur = {out_ch, out_data, out_negzero, out_sat};
    if (RESET) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 32'({out_valid, cur}), 32'({1'b1, prev_out}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, expected no word at %0t", cur, $time);
        end else begin
          out_t e;
          e = sb.pop_front();
          chk("out_word", 32'(cur), 32'(e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
      if (in_valid && !in_ready) saw_block = 1'b1;
    end
  end

  // All driver tasks start and end at posedge + 1.
  task automatic send(input vec_t v);
    int t = 0;
    in_valid = 1'b1;
    in_data  = v.data;
    in_ch    = v.ch;
    @(negedge CLK);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge CLK);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'(1));
    else sb.push_back({v.ch, v.exp, v.nz, v.sat});
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [CH_W-1:0] ch, input logic m);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = m;
    @(posedge CLK); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'(0));
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(2'd0, 8'h85, 8'hFB, 1'b0, 1'b0);
    tbl[1] = mk(2'd0, 8'h05, 8'h05, 1'b0, 1'b0);
    tbl[2] = mk(2'd0, 8'h80, 8'h00, 1'b1, 1'b0);
    tbl[3] = mk(2'd0, 8'hFF, 8'h81, 1'b0, 1'b0);
    tbl[4] = mk(2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[5] = mk(2'd2, 8'hFB, 8'h85, 1'b0, 1'b0);
    tbl[6] = mk(2'd2, 8'h80, 8'hFF, 1'b0, 1'b1);
    tbl[7] = mk(2'd2, 8'h7F, 8'h7F, 1'b0, 1'b0);
    tbl[8] = mk(2'd2, 8'h81, 8'hFF, 1'b0, 1'b0);
    tbl[9] = mk(2'd2, 8'h00, 8'h00, 1'b0, 1'b0);

    RESET = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = 1'b0; evt_clear = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_ch", 32'(out_ch), 32'(0));
    chk("rst_flags", 32'({out_negzero, out_sat}), 32'(0));
    chk("rst_evt_count", 32'(evt_count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));

    // Two-cycle latency from acceptance.
    send(tbl[0]);
    @(negedge CLK);
    chk("latency_cyc1_valid", 32'(out_valid), 32'(0));
    @(negedge CLK);
    chk("latency_cyc2_valid", 32'(out_valid), 32'(1));
    @(posedge CLK); #1;
    drain();

    cfg(2'd2, 1'b1);
    for (int i = 0; i < 10; i++) send(tbl[i]);
    drain();
    chk("evt_after_table", 32'(evt_count), 32'(2));

    // Back-pressure: out_ready low for four cycles mid-stream.
    saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(tbl[i]);
      end
      begin
        repeat (2) @(posedge CLK);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge CLK);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("in_ready_blocked", 32'(saw_block), 32'(1));

    // Coincident config write on ch1: this word still uses the old mode.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mode = 1'b1;
    send(mk(2'd1, 8'h85, 8'hFB, 1'b0, 1'b0));
    cfg_we = 1'b0;
    send(mk(2'd1, 8'hFB, 8'h85, 1'b0, 1'b0));
    drain();

    // Counter: clear, single step, saturation at 15.
    evt_clear = 1'b1;
    @(posedge CLK); #1;
    evt_clear = 1'b0;
    chk("evt_cleared", 32'(evt_count), 32'(0));
    send(tbl[2]);
    drain();
    chk("evt_one", 32'(evt_count), 32'(1));
    for (int i = 0; i < 19; i++) send(tbl[2]);
    drain();
    chk("evt_saturated", 32'(evt_count), 32'(15));

    // Clear coincident with a counted transfer.
    begin
      int t = 0;
      out_ready = 1'b0;
      send(tbl[6]);
      while (!out_valid && t < 20) begin
        @(negedge CLK);
        t++;
      end
      chk("clr_wait_valid", 32'(out_valid), 32'(1));
      @(posedge CLK); #1;
      out_ready = 1'b1; evt_clear = 1'b1;
      @(posedge CLK); #1;
      evt_clear = 1'b0;
      chk("evt_clear_wins", 32'(evt_count), 32'(0));
    end

    // Reset with two words in flight.
    send(tbl[2]);
    drain();
    chk("evt_before_reset", 32'(evt_count), 32'(1));
    out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[3]);
    RESET = 1'b1;
    sb.delete();
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_evt_count", 32'(evt_count), 32'(0));
    out_ready = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    send(mk(2'd2, 8'h80, 8'h00, 1'b1, 1'b0));
    send(mk(2'd1, 8'h80, 8'h00, 1'b1, 1'b0));
    drain();
    chk("evt_after_reset", 32'(evt_count), 32'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
